// File: rtl/nibbler_phase_seq_pkg.sv
// Shared types and constants for the Nibbler fetch/execute sequencer.
// Control-word bit indices must track the microcode decoder's encoding.
package nibbler_pkg;

    localparam int PC_W_DEF  = 12;
    localparam int CNT_W_DEF = 16;
    localparam int CW_W      = 13;
    localparam int ROM_W     = 16;

    localparam int CW_LOADPC   = 12;
    localparam int CW_LOADA    = 11;
    localparam int CW_LOADFLAG = 10;
    localparam int CW_CSRAM    = 3;
    localparam int CW_WERAM    = 2;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] OP_JC   = 4'h0;
    localparam logic [3:0] OP_JNC  = 4'h1;
    localparam logic [3:0] OP_CMPI = 4'h2;
    localparam logic [3:0] OP_CMPM = 4'h3;
    localparam logic [3:0] OP_LIT  = 4'h4;
    localparam logic [3:0] OP_IN   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JNZ  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_ADDM = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_NORI = 4'hE;
    localparam logic [3:0] OP_NORM = 4'hF;

endpackage

// File: rtl/nibbler_phase_seq_if.sv
// ROM / decoder / datapath bus between the sequencer (master) and the rest of the core (slave).
interface nibbler_phase_seq_if #(
    parameter int PC_W = nibbler_pkg::PC_W_DEF
);
    logic [PC_W-1:0]              pc;
    logic [nibbler_pkg::ROM_W-1:0] rom_data;
    logic                         phase;
    logic [3:0]                   instr;
    logic [3:0]                   oprnd;
    logic [nibbler_pkg::CW_W-1:0]  cw;
    logic                         cw_valid;
    logic                         mem_req;
    logic                         mem_ready;
    logic                         alu_c;
    logic                         alu_z;
    logic                         flag_c;
    logic                         flag_z;

    modport master (
        output pc, phase, instr, oprnd, cw_valid, mem_req, flag_c, flag_z,
        input  rom_data, cw, mem_ready, alu_c, alu_z
    );

    modport slave (
        input  pc, phase, instr, oprnd, cw_valid, mem_req, flag_c, flag_z,
        output rom_data, cw, mem_ready, alu_c, alu_z
    );
endinterface

// File: rtl/nibbler_phase_seq.sv
// Fetch/execute sequencer for the 4-bit Nibbler core: PC, fetch register, flags, run/halt/step.
// Optional PC breakpoint when NIBBLER_BREAKPOINT_EN is defined.
module nibbler_phase_seq
    import nibbler_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
`ifdef NIBBLER_BREAKPOINT_EN
    input  logic             brk_en,
    input  logic [PC_W-1:0]  brk_addr,
    output logic             brk_hit,
`endif
    nibbler_phase_seq_if.master bus
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [ROM_W-1:0]   fetch_q, fetch_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_z_q, flag_z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halt_pend_q, halt_pend_d;
    logic               step_mode_q, step_mode_d;
    logic               stall;
    logic               brk_match;
`ifdef NIBBLER_BREAKPOINT_EN
    logic               brk_hit_q, brk_hit_d;
    logic               brk_skip_q, brk_skip_d;
`endif

    // A stall is an execute cycle whose RAM access has not completed yet.
    assign stall = (state_q == S_EXEC) && bus.cw[CW_CSRAM] && !bus.mem_ready;

`ifdef NIBBLER_BREAKPOINT_EN
    assign brk_match = !brk_skip_q && brk_en && (pc_q == brk_addr);
    assign brk_hit   = brk_hit_q;
`else
    assign brk_match = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HALT;
            pc_q        <= '0;
            fetch_q     <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
`ifdef NIBBLER_BREAKPOINT_EN
            brk_hit_q   <= 1'b0;
            brk_skip_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_q     <= fetch_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            step_mode_q <= step_mode_d;
`ifdef NIBBLER_BREAKPOINT_EN
            brk_hit_q   <= brk_hit_d;
            brk_skip_q  <= brk_skip_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_d     = fetch_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        step_mode_d = step_mode_q;
`ifdef NIBBLER_BREAKPOINT_EN
        brk_hit_d   = brk_hit_q;
        brk_skip_d  = brk_skip_q;
`endif
        case (state_q)
            S_HALT: begin
                // Halt outranks a simultaneous run request; step always proceeds.
                if (step_req || (run_req && !halt_req)) begin
                    state_d     = S_FETCH;
                    step_mode_d = step_req;
`ifdef NIBBLER_BREAKPOINT_EN
                    brk_hit_d   = 1'b0;
                    brk_skip_d  = 1'b1;
`endif
                end
            end
            S_FETCH: begin
`ifdef NIBBLER_BREAKPOINT_EN
                brk_skip_d = 1'b0;
`endif
                if (brk_match) begin
                    state_d     = S_HALT;
                    halt_pend_d = 1'b0;
                    step_mode_d = 1'b0;
`ifdef NIBBLER_BREAKPOINT_EN
                    brk_hit_d   = 1'b1;
`endif
                end else begin
                    if (halt_req) halt_pend_d = 1'b1;
                    fetch_d = bus.rom_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (halt_req) halt_pend_d = 1'b1;
                if (!stall) begin
                    if (bus.cw[CW_LOADPC]) pc_d = fetch_q[PC_W-1:0];
                    if (bus.cw[CW_LOADFLAG]) begin
                        flag_c_d = bus.alu_c;
                        flag_z_d = bus.alu_z;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (halt_pend_q || halt_req || step_mode_q || !run_req) begin
                        state_d     = S_HALT;
                        halt_pend_d = 1'b0;
                        step_mode_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        halted       = (state_q == S_HALT);
        bus.phase    = (state_q == S_EXEC);
        bus.mem_req  = (state_q == S_EXEC) && bus.cw[CW_CSRAM];
        bus.cw_valid = (state_q == S_EXEC) && !stall;
    end

    assign bus.pc      = pc_q;
    assign bus.instr   = fetch_q[15:12];
    assign bus.oprnd   = fetch_q[3:0];
    assign bus.flag_c  = flag_c_q;
    assign bus.flag_z  = flag_z_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_nibbler_phase_seq.sv
// Directed bench for nibbler_phase_seq; the bench plays ROM, microcode decoder and RAM.
module tb_nibbler_phase_seq;
    import nibbler_pkg::*;

    logic        clk;
    logic        reset;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        halted;
    logic [15:0] instr_count;
    logic        mem_ready;
    logic        alu_c;
    logic        alu_z;
    logic [15:0] rom [0:4095];
    int          n_tests;
    int          n_fail;
    int          exp_cnt;
`ifdef NIBBLER_BREAKPOINT_EN
    logic        brk_en;
    logic [11:0] brk_addr;
    logic        brk_hit;
`endif

    nibbler_phase_seq_if #(.PC_W(12)) bus ();

    nibbler_phase_seq #(.PC_W(12), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .halted      (halted),
        .instr_count (instr_count),
`ifdef NIBBLER_BREAKPOINT_EN
        .brk_en      (brk_en),
        .brk_addr    (brk_addr),
        .brk_hit     (brk_hit),
`endif
        .bus         (bus.master)
    );

    function automatic logic [12:0] decode(input logic [3:0] op, input logic ph,
                                           input logic c, input logic z);
        logic [12:0] w;
        w = '0;
        if (ph) begin
            w[CW_CSRAM]    = (op == OP_LD) || (op == OP_ST) || (op == OP_ADDM) ||
                             (op == OP_CMPM) || (op == OP_NORM);
            w[CW_LOADPC]   = (op == OP_JMP) || (op == OP_JC && c) || (op == OP_JNC && !c) ||
                             (op == OP_JZ && z) || (op == OP_JNZ && !z);
            w[CW_LOADFLAG] = (op == OP_ADDI) || (op == OP_ADDM) || (op == OP_CMPI) ||
                             (op == OP_CMPM) || (op == OP_NORI) || (op == OP_NORM);
        end
        return w;
    endfunction

    assign bus.rom_data  = rom[bus.pc];
    assign bus.cw        = decode(bus.instr, bus.phase, bus.flag_c, bus.flag_z);
    assign bus.mem_ready = mem_ready;
    assign bus.alu_c     = alu_c;
    assign bus.alu_z     = alu_z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(output bit ok);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted got %b want 1", halted); end
        n_tests++; if (bus.pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc got %h want 000", bus.pc); end
        n_tests++; if ({bus.phase, bus.cw_valid, bus.mem_req} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got %b want 000", {bus.phase, bus.cw_valid, bus.mem_req}); end
        n_tests++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", instr_count); end
        n_tests++; if ({bus.flag_c, bus.flag_z} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {bus.flag_c, bus.flag_z}); end
    endtask

    task automatic test_first_instr();
        rom[0] = 16'hA005;
        alu_c = 1'b1; alu_z = 1'b0;
        run_req = 1'b1;
        tick();
        n_tests++; if ({halted, bus.phase, bus.cw_valid} !== 3'b000) begin n_fail++; $display("FAIL first_fetch_ctl got %b want 000", {halted, bus.phase, bus.cw_valid}); end
        n_tests++; if (bus.pc !== 12'h000) begin n_fail++; $display("FAIL first_fetch_pc got %h want 000", bus.pc); end
        tick();
        n_tests++; if (bus.pc !== 12'h001) begin n_fail++; $display("FAIL first_exec_pc got %h want 001", bus.pc); end
        n_tests++; if ({bus.phase, bus.cw_valid} !== 2'b11) begin n_fail++; $display("FAIL first_exec_ctl got %b want 11", {bus.phase, bus.cw_valid}); end
        n_tests++; if ({bus.instr, bus.oprnd} !== 8'hA5) begin n_fail++; $display("FAIL first_exec_fetch got %h want a5", {bus.instr, bus.oprnd}); end
        run_req = 1'b0;
        tick();
        exp_cnt = 1;
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL first_halt got %b want 1", halted); end
        n_tests++; if (instr_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL first_count got %0d want %0d", instr_count, exp_cnt); end
        n_tests++; if ({bus.flag_c, bus.flag_z} !== 2'b10) begin n_fail++; $display("FAIL first_flags got %b want 10", {bus.flag_c, bus.flag_z}); end
    endtask

    task automatic test_jumps();
        bit ok;
        rom[12'h001] = 16'hC005;
        rom[12'h005] = 16'hC123;
        rom[12'h123] = 16'hA001;
        rom[12'h124] = 16'h0200;
        rom[12'h125] = 16'hA001;
        rom[12'h126] = 16'h0300;
        do_step(ok);
        n_tests++; if (!ok || bus.pc !== 12'h005) begin n_fail++; $display("FAIL jmp_005 got %h want 005", bus.pc); end
        do_step(ok);
        n_tests++; if (!ok || bus.pc !== 12'h123) begin n_fail++; $display("FAIL jmp_123 got %h want 123", bus.pc); end
        alu_c = 1'b0; alu_z = 1'b1;
        do_step(ok);
        n_tests++; if ({bus.flag_c, bus.flag_z} !== 2'b01) begin n_fail++; $display("FAIL addi_flags got %b want 01", {bus.flag_c, bus.flag_z}); end
        do_step(ok);
        n_tests++; if (!ok || bus.pc !== 12'h125) begin n_fail++; $display("FAIL jc_not_taken got %h want 125", bus.pc); end
        alu_c = 1'b1; alu_z = 1'b0;
        do_step(ok);
        do_step(ok);
        n_tests++; if (!ok || bus.pc !== 12'h300) begin n_fail++; $display("FAIL jc_taken got %h want 300", bus.pc); end
        exp_cnt += 6;
        n_tests++; if (instr_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL jumps_count got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_stall();
        logic exp_v;
        rom[12'h300] = 16'h6005;
        alu_c = 1'b0; alu_z = 1'b1;
        mem_ready = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            exp_v = (i == 3);
            n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL stall_mem_req[%0d] got %b want 1", i, bus.mem_req); end
            n_tests++; if (bus.cw_valid !== exp_v) begin n_fail++; $display("FAIL stall_cw_valid[%0d] got %b want %b", i, bus.cw_valid, exp_v); end
            n_tests++; if ({bus.flag_c, bus.flag_z} !== 2'b10) begin n_fail++; $display("FAIL stall_flags[%0d] got %b want 10", i, {bus.flag_c, bus.flag_z}); end
            tick();
        end
        mem_ready = 1'b1;
        exp_cnt += 1;
        n_tests++; if ({halted, bus.mem_req} !== 2'b10) begin n_fail++; $display("FAIL stall_end got %b want 10", {halted, bus.mem_req}); end
        n_tests++; if (instr_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL stall_count got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_halt_req();
        rom[12'h301] = 16'hA000;
        rom[12'h302] = 16'hA000;
        alu_c = 1'b0; alu_z = 1'b0;
        run_req = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if ({bus.phase, bus.pc} !== {1'b0, 12'h302}) begin n_fail++; $display("FAIL halt_req_fetch got %b/%h want 0/302", bus.phase, bus.pc); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_tests++; if ({halted, bus.phase} !== 2'b01) begin n_fail++; $display("FAIL halt_req_completes got %b want 01", {halted, bus.phase}); end
        tick();
        exp_cnt += 2;
        n_tests++; if ({halted, bus.pc} !== {1'b1, 12'h303}) begin n_fail++; $display("FAIL halt_req_halted got %b/%h want 1/303", halted, bus.pc); end
        run_req = 1'b0;
        n_tests++; if (instr_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL halt_req_count got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        rom[12'h303] = 16'hCFFF;
        rom[12'hFFF] = 16'hA000;
        do_step(ok);
        n_tests++; if (!ok || bus.pc !== 12'hFFF) begin n_fail++; $display("FAIL wrap_pre got %h want fff", bus.pc); end
        do_step(ok);
        exp_cnt += 2;
        n_tests++; if (!ok || bus.pc !== 12'h000) begin n_fail++; $display("FAIL wrap_pc got %h want 000", bus.pc); end
        n_tests++; if (instr_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL step_count got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        rom[0] = 16'hA000;
        rom[1] = 16'hA000;
        alu_c = 1'b1; alu_z = 1'b1;
        run_req = 1'b1;
        tick();
        tick();
        n_tests++; if ({bus.cw_valid, bus.pc} !== {1'b1, 12'h001}) begin n_fail++; $display("FAIL b2b_exec0 got %b/%h want 1/001", bus.cw_valid, bus.pc); end
        tick();
        n_tests++; if ({bus.phase, bus.cw_valid, bus.pc} !== {2'b00, 12'h001}) begin n_fail++; $display("FAIL b2b_fetch1 got %b%b/%h want 00/001", bus.phase, bus.cw_valid, bus.pc); end
        tick();
        n_tests++; if ({bus.cw_valid, bus.pc} !== {1'b1, 12'h002}) begin n_fail++; $display("FAIL b2b_exec1 got %b/%h want 1/002", bus.cw_valid, bus.pc); end
        run_req = 1'b0;
        tick();
        exp_cnt += 2;
        n_tests++; if ({halted, instr_count} !== {1'b1, exp_cnt[15:0]}) begin n_fail++; $display("FAIL b2b_end got %b/%0d want 1/%0d", halted, instr_count, exp_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        rom[2] = 16'h6003;
        mem_ready = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_stall_req got %b want 1", bus.mem_req); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        n_tests++; if ({halted, bus.phase, bus.cw_valid, bus.mem_req} !== 4'b1000) begin n_fail++; $display("FAIL rst_stall_ctl got %b want 1000", {halted, bus.phase, bus.cw_valid, bus.mem_req}); end
        n_tests++; if ({bus.pc, bus.instr, bus.oprnd} !== 20'h0) begin n_fail++; $display("FAIL rst_stall_regs got %h want 00000", {bus.pc, bus.instr, bus.oprnd}); end
        n_tests++; if ({bus.flag_c, bus.flag_z, instr_count} !== 18'h0) begin n_fail++; $display("FAIL rst_stall_flags_cnt got %h want 00000", {bus.flag_c, bus.flag_z, instr_count}); end
        mem_ready = 1'b1;
    endtask

`ifdef NIBBLER_BREAKPOINT_EN
    task automatic test_breakpoint();
        bit ok;
        for (int a = 0; a < 6; a++) rom[a] = 16'hA000;
        brk_en = 1'b1;
        brk_addr = 12'h004;
        run_req = 1'b1;
        tick();
        for (int n = 0; n < 30; n++) begin
            if (halted) break;
            tick();
        end
        run_req = 1'b0;
        n_tests++; if ({halted, brk_hit, bus.pc} !== {2'b11, 12'h004}) begin n_fail++; $display("FAIL brk_stop got %b%b/%h want 11/004", halted, brk_hit, bus.pc); end
        do_step(ok);
        n_tests++; if (!ok || {brk_hit, bus.pc} !== {1'b0, 12'h005}) begin n_fail++; $display("FAIL brk_step got %b/%h want 0/005", brk_hit, bus.pc); end
        brk_en = 1'b0;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail = 0;
        exp_cnt = 0;
        reset = 1'b1;
        run_req = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        mem_ready = 1'b1;
        alu_c = 1'b0;
        alu_z = 1'b0;
        for (int a = 0; a < 4096; a++) rom[a] = 16'hA000;
`ifdef NIBBLER_BREAKPOINT_EN
        brk_en = 1'b0;
        brk_addr = 12'h000;
`endif
        test_reset();
        test_first_instr();
        test_jumps();
        test_stall();
        test_halt_req();
        test_wrap();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef NIBBLER_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
